// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the MIPS pipeline (D/E, E/M, M/W).
// It supports stall hold, bubble flush, a saturating Tnew countdown and a per-occupant hold counter.

module pipe_word_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // A bubble that arrives on a load (valid_i = 0) still carries its data words.
  always_ff @(posedge clk) begin
    if (reset || flush) q <= '0;
    else if (en)        q <= d;
  end
endmodule

module pipe_stage_reg #(
  parameter int DATA_W        = 32,
  parameter int NUM_DATA      = 3,
  parameter int CTRL_W        = 12,
  parameter int TNEW_W        = 2,
  parameter int ADDR_W        = 5,
  parameter int CNT_W         = 8,
  parameter int KEEP_PC_FLUSH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       valid_i,
  input  logic                       reg_write_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [NUM_DATA*DATA_W-1:0] data_i,
  input  logic [31:0]                pc_i,
  input  logic                       bd_i,
  input  logic [TNEW_W-1:0]          tnew_i,
  input  logic [ADDR_W-1:0]          a_rs_i,
  input  logic [ADDR_W-1:0]          a_rt_i,
  input  logic [ADDR_W-1:0]          a_wr_i,
  output logic                       valid_o,
  output logic                       reg_write_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [NUM_DATA*DATA_W-1:0] data_o,
  output logic [31:0]                pc_o,
  output logic                       bd_o,
  output logic [TNEW_W-1:0]          tnew_o,
  output logic [ADDR_W-1:0]          a_rs_o,
  output logic [ADDR_W-1:0]          a_rt_o,
  output logic [ADDR_W-1:0]          a_wr_o,
  output logic [CNT_W-1:0]           hold_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       pc;
    logic              bd;
    logic [TNEW_W-1:0] tnew;
    logic [ADDR_W-1:0] a_rs;
    logic [ADDR_W-1:0] a_rt;
    logic [ADDR_W-1:0] a_wr;
  } slot_t;

  slot_t            slot_q, slot_load, slot_flush;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             wr_live;

  // Squash the write early so a dead slot never matches a forwarding compare.
  assign wr_live = reg_write_i & valid_i;

  always_comb begin
    slot_load           = '0;
    slot_load.valid     = valid_i;
    slot_load.reg_write = wr_live;
    slot_load.ctrl      = valid_i ? ctrl_i : '0;
    slot_load.pc        = pc_i;
    slot_load.bd        = bd_i;
    slot_load.tnew      = (!valid_i || tnew_i == '0) ? '0 : tnew_i - 1'b1;
    slot_load.a_rs      = a_rs_i;
    slot_load.a_rt      = a_rt_i;
    slot_load.a_wr      = wr_live ? a_wr_i : '0;
  end

  // A flushed slot may keep its PC/BD so exception logic can still report EPC.
  always_comb begin
    slot_flush = '0;
    if (KEEP_PC_FLUSH != 0) begin
      slot_flush.pc = pc_i;
      slot_flush.bd = bd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      slot_q <= '0;
    else if (flush) slot_q <= slot_flush;
    else if (en)    slot_q <= slot_load;
  end

  always_ff @(posedge clk) begin
    if (reset || flush || en)                  hold_cnt_q <= '0;
    else if (slot_q.valid && hold_cnt_q != '1) hold_cnt_q <= hold_cnt_q + 1'b1;
  end

  for (genvar k = 0; k < NUM_DATA; k++) begin : g_word
    pipe_word_reg #(.W(DATA_W)) u_word (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .en    (en),
      .d     (data_i[k*DATA_W +: DATA_W]),
      .q     (data_o[k*DATA_W +: DATA_W])
    );
  end

  assign valid_o     = slot_q.valid;
  assign reg_write_o = slot_q.reg_write;
  assign ctrl_o      = slot_q.ctrl;
  assign pc_o        = slot_q.pc;
  assign bd_o        = slot_q.bd;
  assign tnew_o      = slot_q.tnew;
  assign a_rs_o      = slot_q.a_rs;
  assign a_rt_o      = slot_q.a_rt;
  assign a_wr_o      = slot_q.a_wr;
  assign hold_cnt_o  = hold_cnt_q;

endmodule
